// File: rtl/mul_pipe_param.sv
// mul_pipe_param: parametrised RV64 M-extension integer multiplier.
// The product is resolved on entry and carried down a rigid LAT-deep shift
// register with valid bits, ROB/PRF tags, valid/ready backpressure and a
// whole-pipe flush. The last stage drives the outputs directly.
module mul_pipe_param #(
    parameter int W     = 64,   // operand/result width (32 or 64)
    parameter int LAT   = 3,    // stages from accept to out_valid (1..8)
    parameter int ROB_W = 6,
    parameter int PRF_W = 7
) (
    input  logic             clk,
    input  logic             reset,        // synchronous, active-low
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mode,
    input  logic [W-1:0]     src_a,
    input  logic [W-1:0]     src_b,
    input  logic [ROB_W-1:0] rob_ptr_in,
    input  logic [PRF_W-1:0] prf_ptr_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     y,
    output logic [ROB_W-1:0] rob_ptr_out,
    output logic [PRF_W-1:0] prf_ptr_out,
    output logic             busy
);

    // Reserved encodings 5..7 fall into the MUL default arm.
    typedef enum logic [2:0] {
        MODE_MUL    = 3'd0,
        MODE_MULH   = 3'd1,
        MODE_MULHSU = 3'd2,
        MODE_MULHU  = 3'd3,
        MODE_MULW   = 3'd4
    } mode_e;

    typedef struct packed {
        logic [W-1:0]     res;
        logic [ROB_W-1:0] rob;
        logic [PRF_W-1:0] prf;
    } stage_t;

    logic [LAT-1:0]     valid_q, valid_d;
    stage_t [LAT-1:0]   stage_q, stage_d;
    stage_t             entry;

    logic               advance;
    logic               a_signed, b_signed;
    logic signed [W:0]  a_ext, b_ext;
    logic [2*W-1:0]     prod;
    logic [31:0]        w_lo;
    logic [W-1:0]       res;

    // Operand extension: one extra bit lets a single signed multiplier
    // cover signed, unsigned and mixed-sign operand pairs.
    assign a_signed = (mode == MODE_MULH) || (mode == MODE_MULHSU);
    assign b_signed = (mode == MODE_MULH);
    assign a_ext    = $signed({a_signed & src_a[W-1], src_a});
    assign b_ext    = $signed({b_signed & src_b[W-1], src_b});

    // Low 2W bits of the (W+1)x(W+1) signed product are the exact 2W-bit P.
    assign prod = (2*W)'(a_ext) * (2*W)'(b_ext);
    assign w_lo = src_a[31:0] * src_b[31:0];

    // Result select per mode; MULW only exists for a 64-bit datapath.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        res = prod[W-1:0];
        case (mode)
            MODE_MULH, MODE_MULHSU, MODE_MULHU: res = prod[2*W-1:W];
            MODE_MULW: if (W == 64) res = W'($signed(w_lo));
            default: ;
        endcase
    end

    assign entry = '{res: res, rob: rob_ptr_in, prf: prf_ptr_in};

    // The whole pipe moves together whenever the output slot can empty.
    assign advance  = ~valid_q[LAT-1] | out_ready;
    assign in_ready = advance;

    // Next state: rigid shift on advance, hold otherwise; flush kills all valids.
    always_comb begin
        valid_d = valid_q;
        stage_d = stage_q;
        if (advance) begin
            for (int i = LAT - 1; i > 0; i--) begin
                valid_d[i] = valid_q[i-1];
                stage_d[i] = stage_q[i-1];
            end
            valid_d[0] = in_valid;
            stage_d[0] = entry;
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Stage registers with synchronous active-low reset; reset beats flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: data/tag registers are reset as well because y and the tags are visible outputs that must read zero after reset.
            valid_q <= '0;
            stage_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every stage samples its predecessor's pre-edge value.
            valid_q <= valid_d;
            stage_q <= stage_d;
        end
    end

    assign out_valid   = valid_q[LAT-1];
    assign y           = stage_q[LAT-1].res;
    assign rob_ptr_out = stage_q[LAT-1].rob;
    assign prf_ptr_out = stage_q[LAT-1].prf;
    assign busy        = |valid_q;

endmodule

// File: tb/tb_mul_pipe_param.sv
// Testbench for mul_pipe_param: directed scenarios on a W=64/LAT=3 instance,
// then random regression on four width/latency configurations. A queue of
// expected results is filled on accept and drained on each retirement.
module tb_mul_pipe_param;

    localparam int N = 4;
    localparam int CFG_W   [N] = '{64, 32, 64, 32};
    localparam int CFG_LAT [N] = '{3, 1, 8, 8};

    typedef struct {
        logic [63:0] y;
        logic [5:0]  rob;
        logic [6:0]  prf;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        drv_in_valid, drv_out_ready, drv_flush;
    logic [2:0]  drv_mode;
    logic [63:0] drv_a, drv_b;
    logic [5:0]  drv_rob;
    logic [6:0]  drv_prf;
    logic [1:0]  sel;

    logic        ir [N];
    logic        ov [N];
    logic        bz [N];
    logic [63:0] yy [N];
    logic [5:0]  rb [N];
    logic [6:0]  pf [N];
    logic [31:0] y1, y3;

    logic        s_in_ready, s_out_valid, s_busy;
    logic [63:0] s_y;
    logic [5:0]  s_rob;
    logic [6:0]  s_prf;

    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;
    int          pops  = 0;
    bit          acc;

    mul_pipe_param #(.W(64), .LAT(3)) u_w64_l3 (
        .clk(clk), .reset(rst_n), .in_valid(drv_in_valid && sel == 2'd0), .in_ready(ir[0]),
        .mode(drv_mode), .src_a(drv_a), .src_b(drv_b), .rob_ptr_in(drv_rob), .prf_ptr_in(drv_prf),
        .flush(drv_flush && sel == 2'd0), .out_valid(ov[0]),
        .out_ready(sel == 2'd0 ? drv_out_ready : 1'b1), .y(yy[0]),
        .rob_ptr_out(rb[0]), .prf_ptr_out(pf[0]), .busy(bz[0]));

    mul_pipe_param #(.W(32), .LAT(1)) u_w32_l1 (
        .clk(clk), .reset(rst_n), .in_valid(drv_in_valid && sel == 2'd1), .in_ready(ir[1]),
        .mode(drv_mode), .src_a(drv_a[31:0]), .src_b(drv_b[31:0]), .rob_ptr_in(drv_rob), .prf_ptr_in(drv_prf),
        .flush(drv_flush && sel == 2'd1), .out_valid(ov[1]),
        .out_ready(sel == 2'd1 ? drv_out_ready : 1'b1), .y(y1),
        .rob_ptr_out(rb[1]), .prf_ptr_out(pf[1]), .busy(bz[1]));

    mul_pipe_param #(.W(64), .LAT(8)) u_w64_l8 (
        .clk(clk), .reset(rst_n), .in_valid(drv_in_valid && sel == 2'd2), .in_ready(ir[2]),
        .mode(drv_mode), .src_a(drv_a), .src_b(drv_b), .rob_ptr_in(drv_rob), .prf_ptr_in(drv_prf),
        .flush(drv_flush && sel == 2'd2), .out_valid(ov[2]),
        .out_ready(sel == 2'd2 ? drv_out_ready : 1'b1), .y(yy[2]),
        .rob_ptr_out(rb[2]), .prf_ptr_out(pf[2]), .busy(bz[2]));

    mul_pipe_param #(.W(32), .LAT(8)) u_w32_l8 (
        .clk(clk), .reset(rst_n), .in_valid(drv_in_valid && sel == 2'd3), .in_ready(ir[3]),
        .mode(drv_mode), .src_a(drv_a[31:0]), .src_b(drv_b[31:0]), .rob_ptr_in(drv_rob), .prf_ptr_in(drv_prf),
        .flush(drv_flush && sel == 2'd3), .out_valid(ov[3]),
        .out_ready(sel == 2'd3 ? drv_out_ready : 1'b1), .y(y3),
        .rob_ptr_out(rb[3]), .prf_ptr_out(pf[3]), .busy(bz[3]));

    assign yy[1] = {32'b0, y1};
    assign yy[3] = {32'b0, y3};

    assign s_in_ready  = ir[sel];
    assign s_out_valid = ov[sel];
    assign s_busy      = bz[sel];
    assign s_y         = yy[sel];
    assign s_rob       = rb[sel];
    assign s_prf       = pf[sel];

    // Golden model: 128-bit product of explicitly extended operands.
    function automatic logic [63:0] gold(input logic [2:0] m, input logic [63:0] a,
                                         input logic [63:0] b, input int w);
        logic [127:0] ae, be, p;
        logic         sa, sbs;
        logic [31:0]  lo;
        sa  = (m == 3'd1) || (m == 3'd2);
        sbs = (m == 3'd1);
        if (w == 32) begin
            ae = {{96{sa & a[31]}}, a[31:0]};
            be = {{96{sbs & b[31]}}, b[31:0]};
        end else begin
            ae = {{64{sa & a[63]}}, a};
            be = {{64{sbs & b[63]}}, b};
        end
        p = ae * be;
        case (m)
            3'd1, 3'd2, 3'd3: gold = (w == 32) ? {32'b0, p[63:32]} : p[127:64];
            3'd4: begin
                lo = p[31:0];
                gold = (w == 64) ? {{32{lo[31]}}, lo} : {32'b0, lo};
            end
            default: gold = (w == 32) ? {32'b0, p[31:0]} : p[63:0];
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] m, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] r, input logic [6:0] p);
        drv_in_valid = v;
        drv_mode     = m;
        drv_a        = a;
        drv_b        = b;
        drv_rob      = r;
        drv_prf      = p;
    endtask

    // One clock: evaluate the handshakes at the falling edge, then return
    // just after the next rising edge where new stimulus is applied.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        acc = 1'b0;
        if (!rst_n || drv_flush) begin
            sb.delete();
        end else begin
            if (s_out_valid === 1'b1 && drv_out_ready) begin
                total++;
                pops++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_underflow: got y=%h rob=%0d with no result outstanding", s_y, s_rob);
                end else begin
                    e = sb.pop_front();
                    if (s_y !== e.y || s_rob !== e.rob || s_prf !== e.prf) begin
                        bad++;
                        $display("FAIL sb_result: got y=%h rob=%0d prf=%0d, want y=%h rob=%0d prf=%0d",
                                 s_y, s_rob, s_prf, e.y, e.rob, e.prf);
                    end
                end
            end
            if (drv_in_valid && s_in_ready === 1'b1) begin
                e.y   = gold(drv_mode, drv_a, drv_b, CFG_W[sel]);
                e.rob = drv_rob;
                e.prf = drv_prf;
                sb.push_back(e);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        total++;
        if (s_out_valid !== 1'b0 || s_busy !== 1'b0 || s_y !== 64'd0 || s_rob !== 6'd0 || s_prf !== 7'd0) begin
            bad++;
            $display("FAIL %s: out_valid=%b busy=%b y=%h rob=%0d prf=%0d, want all zero",
                     tag, s_out_valid, s_busy, s_y, s_rob, s_prf);
        end
    endtask

    // Issue one op into an empty pipe, measure its latency and check it.
    task automatic run_one(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b,
                           input logic [5:0] r, input logic [6:0] p, input logic [63:0] exp_y);
        int n;
        drv_out_ready = 1'b1;
        drive(1'b1, m, a, b, r, p);
        tick();
        drv_in_valid = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL accept: op not accepted into idle pipe");
        end
        n = 1;
        while (s_out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n != CFG_LAT[sel]) begin
            bad++;
            $display("FAIL latency: got %0d cycles, want %0d", n, CFG_LAT[sel]);
        end
        total++;
        if (s_y !== exp_y || s_rob !== r || s_prf !== p) begin
            bad++;
            $display("FAIL run_one_value: got y=%h rob=%0d prf=%0d, want y=%h rob=%0d prf=%0d",
                     s_y, s_rob, s_prf, exp_y, r, p);
        end
        tick();
    endtask

    task automatic test_reset();
        sel = 2'd0;
        rst_n = 1'b0;
        drv_flush = 1'b0;
        drv_out_ready = 1'b1;
        drive(1'b0, 3'd0, 64'd0, 64'd0, 6'd0, 7'd0);
        tick();
        tick();
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        tick();
        total++;
        if (s_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b, want 1", s_in_ready);
        end
    endtask

    task automatic test_mul_basic();
        run_one(3'd0, 64'd7, -64'sd3, 6'd5, 7'd9, 64'hFFFF_FFFF_FFFF_FFEB);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  mm [4] = '{3'd1, 3'd3, 3'd2, 3'd4};
        logic [63:0] aa [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_7FFF_FFFF};
        logic [63:0] bb [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd2};
        logic [63:0] ee [4] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFE,
                                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
        int k;
        k = 0;
        drv_out_ready = 1'b1;
        for (int c = 0; c < CFG_LAT[sel] + 6; c++) begin
            if (c < 4) drive(1'b1, mm[c], aa[c], bb[c], 6'(10 + c), 7'(20 + c));
            else       drv_in_valid = 1'b0;
            tick();
            if (s_out_valid === 1'b1) begin
                total++;
                if (k > 3 || k != c - CFG_LAT[sel] + 1 || s_y !== ee[k] || s_rob !== 6'(10 + k)) begin
                    bad++;
                    $display("FAIL back_to_back: cycle %0d slot %0d y=%h rob=%0d", c, k, s_y, s_rob);
                end
                k++;
            end
        end
        total++;
        if (k != 4) begin
            bad++;
            $display("FAIL back_to_back_count: got %0d results, want 4", k);
        end
    endtask

    task automatic test_backpressure();
        int j, stall, cyc, p0;
        bit seen, stalling;
        logic [63:0] held_y;
        j = 0; stall = 0; cyc = 0; seen = 0; p0 = pops; held_y = '0;
        while ((j < 5 || sb.size() != 0) && cyc < 80) begin
            if (!seen && s_out_valid === 1'b1) seen = 1'b1;
            stalling = seen && stall < 6;
            drv_out_ready = !stalling;
            if (j < 5) drive(1'b1, 3'(j), 64'h1234_5678_9ABC_DEF0 + 64'(j), -64'sd5 - 64'(j), 6'(30 + j), 7'(40 + j));
            else       drv_in_valid = 1'b0;
            #1;
            if (stalling) begin
                if (stall == 0) begin
                    held_y = s_y;
                end else begin
                    total++;
                    if (s_y !== held_y) begin
                        bad++;
                        $display("FAIL y_hold: got %h, want %h", s_y, held_y);
                    end
                end
                total++;
                if (s_in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL in_ready_stall: got %b, want 0", s_in_ready);
                end
                stall++;
            end
            tick();
            if (acc) j++;
            cyc++;
        end
        drv_in_valid = 1'b0;
        drv_out_ready = 1'b1;
        total++;
        if (pops - p0 != 5 || stall != 6) begin
            bad++;
            $display("FAIL backpressure_retire: got %0d retired %0d stalls, want 5 and 6", pops - p0, stall);
        end
    endtask

    task automatic test_flush();
        int late;
        drv_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd0, 64'(100 + i), 64'd3, 6'(50 + i), 7'(60 + i));
            tick();
        end
        drive(1'b1, 3'd0, 64'd999, 64'd3, 6'd55, 7'd65);
        drv_flush = 1'b1;
        tick();
        drv_flush = 1'b0;
        drv_in_valid = 1'b0;
        total++;
        if (s_busy !== 1'b0 || s_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_busy: got busy=%b out_valid=%b, want 0 0", s_busy, s_out_valid);
        end
        late = 0;
        for (int i = 0; i < CFG_LAT[sel]; i++) begin
            tick();
            if (s_out_valid !== 1'b0) late++;
        end
        total++;
        if (late != 0) begin
            bad++;
            $display("FAIL flush_quiet: got %0d cycles with out_valid, want 0", late);
        end
        run_one(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd7, 7'd8, 64'd1);
    endtask

    task automatic test_reset_mid();
        int late;
        drv_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'd0, 64'(7 + i), 64'd9, 6'(20 + i), 7'(30 + i));
            tick();
        end
        drv_in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check_outputs_zero("reset_mid_state");
        rst_n = 1'b1;
        #1;
        total++;
        if (s_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_in_ready: got %b, want 1", s_in_ready);
        end
        late = 0;
        for (int i = 0; i < CFG_LAT[sel] + 3; i++) begin
            tick();
            if (s_out_valid !== 1'b0) late++;
        end
        total++;
        if (late != 0) begin
            bad++;
            $display("FAIL reset_mid_ghost: got %0d late results, want 0", late);
        end
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       rand_operand = {$urandom, $urandom};
            1:       rand_operand = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       rand_operand = {1'b1, 63'd0} | 64'($urandom_range(0, 7));
            default: rand_operand = {32'hFFFF_FFFF, 1'b1, 31'($urandom)};
        endcase
    endfunction

    task automatic test_random(input logic [1:0] s);
        int n, p0;
        sel = s;
        p0 = pops;
        for (int c = 0; c < 500; c++) begin
            drive($urandom_range(0, 99) < 70, 3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
                  6'($urandom), 7'($urandom));
            drv_out_ready = $urandom_range(0, 99) < 75;
            drv_flush     = $urandom_range(0, 99) < 3;
            tick();
        end
        drv_flush = 1'b0;
        drv_in_valid = 1'b0;
        drv_out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (sb.size() != 0 || s_busy !== 1'b0 || pops == p0) begin
            bad++;
            $display("FAIL random_drain cfg%0d: %0d results missing busy=%b retired=%0d",
                     s, sb.size(), s_busy, pops - p0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul_basic();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        for (int s = 0; s < N; s++) test_random(2'(s));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_pipe_param.md
Name: mul_pipe_param

Overview:
- Parametrised successor of the core's pipelined integer multiplier: W-bit operands, configurable pipeline depth LAT, RV64 M-extension modes (MUL/MULH/MULHSU/MULHU/MULW).
- Adds valid/ready backpressure and a whole-pipe flush.
- Sits in the execute cluster between the issue queue and the writeback/complete bus.
- Carries ROB and PRF tags alongside each operation.

Parameters:
- W, 64, operand/result width (32 or 64; MULW legal only when W=64).
- LAT, 3, stages from accept to out_valid (1..8).
- ROB_W, 6, ROB pointer width.
- PRF_W, 7, physical register pointer width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid & in_ready.
- mode  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5-7 treated as MUL.
- src_a  in  W  multiplicand (signed for MULH/MULHSU).
- src_b  in  W  multiplier (signed for MULH only).
- rob_ptr_in  in  ROB_W  tag.
- prf_ptr_in  in  PRF_W  destination tag.
- flush  in  1  kill all in-flight operations.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts result.
- y  out  W  result.
- rob_ptr_out  out  ROB_W  tag of y.
- prf_ptr_out  out  PRF_W  tag of y.
- busy  out  1  any stage valid.

Behaviour:
- Reset (reset==0 at posedge): all stage valid bits cleared; tags and y zeroed. out_valid=0, busy=0, y=0, rob_ptr_out=0, prf_ptr_out=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation discards every in-flight op; no result emerges later.
- Pipeline: LAT stage registers, each with valid, mode, tags and partial datapath state. Stage LAT-1 drives the outputs directly; no combinational path from src_* to y.
- advance = ~out_valid | out_ready. When advance=1, all stages shift by one. When advance=0, all stages hold.
- Bubbles are not squeezed; pipe is a rigid shift register.
- in_ready = advance. Combinational from out_valid/out_ready only, never from in_valid.
- Latency: with out_ready held 1, an op accepted at edge T has out_valid=1 in the cycle after edge T+LAT-1, i.e. LAT cycles after acceptance.
- Throughput: one op per cycle. Results leave in acceptance order.
- Arithmetic: full 2W-bit product P of operands extended per mode.
  - MUL: y=P[W-1:0].
  - MULH: signed×signed, y=P[2W-1:W].
  - MULHSU: signed a × unsigned b, y=P[2W-1:W].
  - MULHU: unsigned×unsigned, y=P[2W-1:W].
  - MULW: a[31:0]×b[31:0], y = sign-extend of the 32-bit low product to W.
- Products are exact two's complement; no saturation.
- Reduction may be split across stages freely (CSA tree plus final add), provided every op's value is independent of neighbouring ops and of stalls.
- Flush: at a posedge with flush=1, all stage valid bits clear, including the output stage even if out_ready=1 that cycle. in_valid in the same cycle is dropped, not accepted. Data/tag registers may retain stale values.
- Flush while stalled behaves identically.
- Simultaneous flush and reset: reset wins, with the same visible effect.
- busy = OR of all stage valid bits. It falls the cycle after the last result is taken or flushed.
- y/tags hold stable while out_valid=1 & out_ready=0.
- Reserved mode values behave exactly as MUL.
- MULW with W=32 is treated as MUL.

Test Plan:
1. W=64, LAT=3, out_ready=1; MUL a=7, b=-3 -> out_valid 3 cycles after accept, y=0xFFFF_FFFF_FFFF_FFEB, tags echoed.
2. Modes, back-to-back one per cycle -> results on consecutive cycles in order:
   - MULH -1×-1 -> y=0.
   - MULHU 0xFFFF_FFFF_FFFF_FFFF×same -> y=0xFFFF_FFFF_FFFF_FFFE.
   - MULHSU a=-1, b=2 -> y=0xFFFF_FFFF_FFFF_FFFF.
   - MULW a=0x7FFF_FFFF, b=2 -> y=0xFFFF_FFFF_FFFF_FFFE.
3. Backpressure: issue 5 ops continuously, out_ready=0 for 6 cycles after the first result appears -> in_ready drops once the output stage is full; y holds; all 5 results retire in order once out_ready=1, none lost or duplicated.
4. Flush: 3 ops in flight, flush=1 with in_valid=1 -> no out_valid for the next LAT cycles; busy=0 the next cycle; an op issued after flush returns its correct result at latency LAT.
5. Reset mid-op: drive reset=0 for one cycle while 2 ops are in flight -> out_valid, busy, y, tags all 0; no later result; in_ready=1 after release.
6. Random regression, W=32 and W=64, LAT in {1,3,8}, random stalls/flushes -> every non-flushed op matches a golden model product per mode.
